// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot loader:
// memory geometry, loader state encoding and header field widths.
package imem_pkg;

   localparam int IMEM_ADDR_W = 10;
   localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

   // Stream framing: 16-bit little-endian word count, then 8-bit bytes.
   localparam int HDR_COUNT_W = 16;
   localparam int BYTE_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_HDR_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } ld_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four consecutive stream bytes into a little-endian 32-bit word.
// o_word_valid is a combinational strobe on the fourth byte handshake and
// o_word is valid only while it is high.
module imem_word_packer
   import imem_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_byte_hs,
   input  logic [BYTE_W-1:0] i_byte_data,
   output logic              o_word_valid,
   output logic [31:0]       o_word
);

   logic [1:0]  byte_cnt_q;
   logic [23:0] shift_q;

   // Newest byte enters at the top, so after three bytes shift_q = {b2,b1,b0}.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
      end else if (i_clr) begin
         byte_cnt_q <= 2'd0;
      end else if (i_byte_hs) begin
         byte_cnt_q <= byte_cnt_q + 2'd1;
         shift_q    <= {i_byte_data, shift_q[23:8]};
      end
   end

   assign o_word_valid = i_byte_hs & (byte_cnt_q == 2'd3);
   assign o_word       = {i_byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a word-count header, packs the
// following bytes into words, writes them from index 0 upward and holds the
// core in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int WORD_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_byte_valid,
   input  logic [BYTE_W-1:0] i_byte_data,
   output logic              o_byte_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [WORD_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_cpu_hold
);

   localparam logic [HDR_COUNT_W:0] DEPTH_L = (HDR_COUNT_W+1)'(1 << ADDR_W);

   ld_state_e              state_q;
   logic                   byte_ready_q, busy_q, done_q, err_q, hold_q;
   logic                   fin_q;
   logic [HDR_COUNT_W-1:0] word_cnt_q;
   logic [ADDR_W:0]        widx_q;
   logic                   we_q;
   logic [ADDR_W-1:0]      waddr_q;
   logic [WORD_W-1:0]      wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]      csum_q;
`endif

   logic                   hs, data_hs, start_ok, word_valid, last_word;
   logic [31:0]            word;
   logic [HDR_COUNT_W-1:0] hdr_count_d;

   assign hs          = i_byte_valid & byte_ready_q;
   assign data_hs     = hs & (state_q == ST_DATA);
   assign start_ok    = i_start & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                   (state_q == ST_ERR));
   assign hdr_count_d = {i_byte_data, word_cnt_q[7:0]};
   assign last_word   = (HDR_COUNT_W'(widx_q) + 16'd1) == word_cnt_q;

   imem_word_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (start_ok),
      .i_byte_hs    (data_hs),
      .i_byte_data  (i_byte_data),
      .o_word_valid (word_valid),
      .o_word       (word)
   );

   // Write port: one registered pulse per completed word, index advances after it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         widx_q  <= '0;
      end else begin
         we_q <= word_valid;
         if (start_ok) begin
            widx_q <= '0;
         end else if (word_valid) begin
            waddr_q <= widx_q[ADDR_W-1:0];
            wdata_q <= word;
            widx_q  <= widx_q + 1'b1;
         end
      end
   end

   // Loader FSM with all status outputs registered alongside the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         hold_q       <= 1'b1;
         fin_q        <= 1'b0;
         word_cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (start_ok) csum_q <= '0;
         else if (data_hs) csum_q <= csum_q ^ i_byte_data;
`endif
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_ok) begin
                  state_q      <= ST_HDR_LO;
                  byte_ready_q <= 1'b1;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  err_q        <= 1'b0;
                  hold_q       <= 1'b1;
                  fin_q        <= 1'b0;
               end
            end
            ST_HDR_LO: begin
               if (hs) begin
                  word_cnt_q[7:0] <= i_byte_data;
                  state_q         <= ST_HDR_HI;
               end
            end
            ST_HDR_HI: begin
               if (hs) begin
                  word_cnt_q <= hdr_count_d;
                  if (hdr_count_d == '0) begin
                     // Empty image: take the same one-cycle finishing step as a full one.
                     state_q      <= ST_DATA;
                     byte_ready_q <= 1'b0;
                     fin_q        <= 1'b1;
                  end else if ({1'b0, hdr_count_d} > DEPTH_L) begin
                     state_q      <= ST_ERR;
                     byte_ready_q <= 1'b0;
                     busy_q       <= 1'b0;
                     err_q        <= 1'b1;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (fin_q) begin
                  fin_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_q      <= ST_CHK;
                  byte_ready_q <= 1'b1;
`else
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
`endif
               end else if (word_valid && last_word) begin
                  // Stop accepting while the final write pulse is on the port.
                  byte_ready_q <= 1'b0;
                  fin_q        <= 1'b1;
               end
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (hs) begin
                  byte_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
                  if (i_byte_data == csum_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end
               end
`else
               state_q <= ST_IDLE;
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_byte_ready = byte_ready_q;
   assign o_we         = we_q;
   assign o_waddr      = waddr_q;
   assign o_wdata      = wdata_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;
   assign o_cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word packing, write pulses,
// error path, restart and asynchronous reset. Handles IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        bvalid;
   logic [7:0]  bdata;
   logic        bready;
   logic        we;
   logic [9:0]  waddr;
   logic [31:0] wdata;
   logic        busy, done, err, hold;

   int total = 0;
   int bad   = 0;

   // write log filled by the monitor process only
   int          wr_n    = 0;
   int          run     = 0;
   int          max_run = 0;
   logic [9:0]  wr_addr [64];
   logic [31:0] wr_data [64];

   imem_loader dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_byte_valid (bvalid),
      .i_byte_data  (bdata),
      .o_byte_ready (bready),
      .o_we         (we),
      .o_waddr      (waddr),
      .o_wdata      (wdata),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_cpu_hold   (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: record every write-enable cycle and the longest o_we run
   initial begin
      forever begin
         @(negedge clk);
         if (we === 1'b1) begin
            if (wr_n < 64) begin
               wr_addr[wr_n] = waddr;
               wr_data[wr_n] = wdata;
            end
            wr_n++;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // present one byte and return #1 after the edge on which it was accepted
   task automatic send(input logic [7:0] b);
      logic rdy;
      int   guard;
      guard  = 0;
      bvalid = 1'b1;
      bdata  = b;
      forever begin
         rdy = bready;
         tick();
         if (rdy) break;
         guard++;
         if (guard > 100) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=no_ready expected=ready byte=%h", b);
            break;
         end
      end
      bvalid = 1'b0;
   endtask

   initial begin
      int          base;
      logic [7:0]  cs;
      logic [31:0] wv;
      logic [31:0] words [4];

      rst_n  = 1'b0;
      start  = 1'b0;
      bvalid = 1'b0;
      bdata  = 8'h00;
      tick();
      tick();

      // reset state
      chk("rst_ready", bready, 0);
      chk("rst_we",    we,     0);
      chk("rst_waddr", waddr,  0);
      chk("rst_wdata", wdata,  0);
      chk("rst_busy",  busy,   0);
      chk("rst_done",  done,   0);
      chk("rst_err",   err,    0);
      chk("rst_hold",  hold,   1);
      rst_n = 1'b1;
      tick();

      // two-word image, valid held high
      base = wr_n;
      pulse_start();
      chk("t1_busy",  busy,   1);
      chk("t1_ready", bready, 1);
      send(8'h02); send(8'h00);
      send(8'h93); send(8'h85); send(8'h15); send(8'h00);
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      chk("t1_last_we",    we,     1);
      chk("t1_last_addr",  waddr,  1);
      chk("t1_last_ready", bready, 0);
      chk("t1_early_done", done,   0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h03);
`else
      tick();
`endif
      chk("t1_done", done, 1);
      chk("t1_hold", hold, 0);
      chk("t1_busy_end", busy, 0);
      tick(); tick();
      chk("t1_nwr",   wr_n - base, 2);
      chk("t1_addr0", wr_addr[base],   0);
      chk("t1_data0", wr_data[base],   32'h00158593);
      chk("t1_addr1", wr_addr[base+1], 1);
      chk("t1_data1", wr_data[base+1], 32'h00000000);

      // valid while not ready is ignored
      bvalid = 1'b1; bdata = 8'hAA;
      tick(); tick(); tick();
      bvalid = 1'b0;
      chk("ign_nwr",  wr_n - base, 2);
      chk("ign_done", done, 1);

      // zero-length image
      base = wr_n;
      pulse_start();
      chk("t2_done_clr", done, 0);
      chk("t2_hold",     hold, 1);
      send(8'h00); send(8'h00);
      chk("t2_done_early", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00);
`else
      tick();
`endif
      chk("t2_done", done, 1);
      tick();
      chk("t2_nwr", wr_n - base, 0);

      // oversize header 1025 -> error, then a good restart
      base = wr_n;
      pulse_start();
      send(8'h01); send(8'h04);
      chk("t3_err",   err,    1);
      chk("t3_hold",  hold,   1);
      chk("t3_busy",  busy,   0);
      chk("t3_ready", bready, 0);
      tick(); tick();
      chk("t3_nwr", wr_n - base, 0);
      pulse_start();
      chk("t3_err_clr", err, 0);
      send(8'h01); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h08);
`else
      tick();
`endif
      chk("t3_done", done, 1);
      tick();
      chk("t3_nwr2",  wr_n - base, 1);
      chk("t3_addr0", wr_addr[base], 0);
      chk("t3_data0", wr_data[base], 32'h12345678);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum mismatch
      pulse_start();
      send(8'h01); send(8'h00);
      send(8'h93); send(8'h85); send(8'h15); send(8'h00);
      send(8'h04);
      chk("ck_err",  err,  1);
      chk("ck_done", done, 0);
      chk("ck_hold", hold, 1);
`endif

      // four words with random gaps on valid
      words[0] = 32'h11223344;
      words[1] = 32'hA5A5F00F;
      words[2] = 32'hDEADBEEF;
      words[3] = 32'h00000001;
      base = wr_n;
      cs   = 8'h00;
      pulse_start();
      send(8'h04); send(8'h00);
      for (int w = 0; w < 4; w++) begin
         wv = words[w];
         for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(wv[8*b +: 8]);
            cs = cs ^ wv[8*b +: 8];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(cs);
`else
      tick();
`endif
      chk("t4_done", done, 1);
      tick();
      chk("t4_nwr", wr_n - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_addr%0d", i), wr_addr[base+i], i);
         chk($sformatf("t4_data%0d", i), wr_data[base+i], words[i]);
      end
      chk("we_pulse_width", max_run, 1);

      // asynchronous reset after six data bytes
      base = wr_n;
      pulse_start();
      send(8'h04); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05); send(8'h06);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ready", bready, 0);
      chk("ar_we",    we,     0);
      chk("ar_waddr", waddr,  0);
      chk("ar_wdata", wdata,  0);
      chk("ar_busy",  busy,   0);
      chk("ar_hold",  hold,   1);
      bvalid = 1'b1; bdata = 8'h07;
      tick(); tick(); tick();
      bvalid = 1'b0;
      rst_n = 1'b1;
      tick(); tick();
      chk("ar_nwr",  wr_n - base, 1);
      chk("ar_idle_ready", bready, 0);
      chk("ar_idle_done",  done,   0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
